median_sort_ctrl: RTL



---
 rtl/median_sort_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/median_sort_ctrl.sv
// Window median/rank selector: loads WINDOW samples, sorts them in place with an
// odd-even transposition sort on one shared compare-exchange cell, then emits one rank.
module median_sort_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int WINDOW    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  input  logic [DATA_SIZE-1:0] inData,
  output logic                 inReady,
  input  logic [3:0]           rankSel,
  output logic                 outValid,
  output logic [DATA_SIZE-1:0] outData,
  input  logic                 outReady,
  output logic                 busy
);

  localparam int IW = $clog2(WINDOW);
  typedef logic [IW-1:0] idx_t;

  localparam idx_t       LAST_IDX  = idx_t'(WINDOW - 1);
  localparam idx_t       LAST_PAIR = idx_t'((WINDOW - 3) / 2);
  localparam idx_t       MID_RANK  = idx_t'((WINDOW - 1) / 2);
  localparam logic [3:0] RANK_MAX  = 4'(WINDOW - 1);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t               state_q, state_d;
  idx_t                 count_q, count_d;
  idx_t                 pass_q,  pass_d;
  idx_t                 pair_q,  pair_d;
  idx_t                 rank_q,  rank_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic [DATA_SIZE-1:0] r_q [WINDOW];
  logic [DATA_SIZE-1:0] r_d [WINDOW];

  idx_t                 a_lo, a_hi;
  logic [DATA_SIZE-1:0] cell_out0, cell_out1;

  // Even passes touch pairs (0,1),(2,3)..; odd passes shift by one to (1,2),(3,4)..
  assign a_lo = idx_t'({pair_q, 1'b0}) + idx_t'(pass_q[0]);
  assign a_hi = a_lo + idx_t'(1);

  medianSort #(.DATA_SIZE(DATA_SIZE)) u_cell (
    .dataIn0  (r_q[a_lo]),
    .dataIn1  (r_q[a_hi]),
    .dataOut0 (cell_out0),
    .dataOut1 (cell_out1)
  );

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    count_d    = count_q;
    pass_d     = pass_q;
    pair_d     = pair_q;
    rank_d     = rank_q;
    out_data_d = out_data_q;
    r_d        = r_q;

    unique case (state_q)
      LOAD: begin
        if (inValid) begin
          r_d[count_q] = inData;
          if (count_q == '0) begin
            rank_d = (rankSel > RANK_MAX) ? LAST_IDX : idx_t'(rankSel);
          end
          if (count_q == LAST_IDX) begin
            count_d = '0;
            pass_d  = '0;
            pair_d  = '0;
            state_d = SORT;
          end else begin
            count_d = count_q + idx_t'(1);
          end
        end
      end
      SORT: begin
        r_d[a_lo] = cell_out0;
        r_d[a_hi] = cell_out1;
        if (pair_q == LAST_PAIR) begin
          pair_d = '0;
          if (pass_q == LAST_IDX) begin
            // Capture from r_d so the final exchange is reflected in the result.
            out_data_d = r_d[rank_q];
            state_d    = OUT;
          end else begin
            pass_d = pass_q + idx_t'(1);
          end
        end else begin
          pair_d = pair_q + idx_t'(1);
        end
      end
      OUT: begin
        if (outReady) begin
          count_d = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      count_q    <= '0;
      pass_q     <= '0;
      pair_q     <= '0;
      rank_q     <= MID_RANK;
      out_data_q <= '0;
      // NOTE: the register file is small and flop-based, so it is cleared on reset like any other state.
      for (int i = 0; i < WINDOW; i++) r_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pass_q     <= pass_d;
      pair_q     <= pair_d;
      rank_q     <= rank_d;
      out_data_q <= out_data_d;
      r_q        <= r_d;
    end
  end

  assign inReady  = (state_q == LOAD);
  assign busy     = (state_q == SORT);
  assign outValid = (state_q == OUT);
  assign outData  = out_data_q;

endmodule

// Compare-exchange cell: larger value on output 0; equal inputs pass straight through.
module medianSort #(
  parameter int DATA_SIZE = 8
) (
  input  logic [DATA_SIZE-1:0] dataIn0,
  input  logic [DATA_SIZE-1:0] dataIn1,
  output logic [DATA_SIZE-1:0] dataOut0,
  output logic [DATA_SIZE-1:0] dataOut1
);

  logic swap;

  assign swap     = (dataIn1 > dataIn0);
  assign dataOut0 = swap ? dataIn1 : dataIn0;
  assign dataOut1 = swap ? dataIn0 : dataIn1;

endmodule
